// File: rtl/msk_rnd_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : msk_rnd_feeder
//  Description : Seeded xorshift64 randomness source feeding a masked core;
//                one step of every lane per consumed cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module msk_rnd_feeder #(
    parameter int RND_WIDTH = 512,
    parameter int WARMUP    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          seed_in,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic                 reseed_req,
    input  logic                 rnd_consume,
    output logic [RND_WIDTH-1:0] rnd_out,
    output logic                 rnd_valid,
    output logic                 starved
);

    localparam int          C_LANES     = RND_WIDTH / 64;
    localparam logic [63:0] C_GOLDEN    = 64'h9E3779B97F4A7C15;
    localparam logic [7:0]  C_WARM_LAST = 8'(WARMUP - 1);

    typedef enum logic [1:0] {
        ST_UNSEEDED = 2'd0,
        ST_SEEDING  = 2'd1,
        ST_WARMUP   = 2'd2,
        ST_READY    = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [1:0]   r_word_cnt;
    logic [1:0]   w_word_cnt_nxt;
    logic [7:0]   r_warm_cnt;
    logic [7:0]   w_warm_cnt_nxt;
    logic         r_load_pend;
    logic         w_load_pend_nxt;
    logic [127:0] r_seed;
    logic         r_starved;

    logic w_seed_wr;
    logic w_seed_clr;
    logic w_lane_zero;
    logic w_lane_load;
    logic w_lane_step;
    logic w_starve_set;

    function automatic logic [63:0] xs_step(input logic [63:0] x);
        logic [63:0] v;
        v = x ^ (x << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    function automatic logic [63:0] rotl64(input logic [63:0] x, input int r);
        logic [127:0] d;
        d = {x, x} << r;
        return d[127:64];
    endfunction

    // A zero state would lock xorshift at zero forever, so substitute 1.
    function automatic logic [63:0] lane_init(input logic [127:0] s, input int idx);
        logic [63:0] v;
        v = s[63:0] ^ rotl64(s[127:64], idx % 64) ^ (C_GOLDEN * 64'(idx + 1));
        return (v == 64'd0) ? 64'd1 : v;
    endfunction

    assign seed_ready = (r_state == ST_UNSEEDED) || (r_state == ST_SEEDING);
    assign rnd_valid  = (r_state == ST_READY);
    assign starved    = r_starved;

    // Reseed wins over everything else arriving in the same cycle.
    assign w_starve_set = rnd_consume && !reseed_req && (r_state != ST_READY);

    always_comb begin
        w_state_nxt     = r_state;
        w_word_cnt_nxt  = r_word_cnt;
        w_warm_cnt_nxt  = r_warm_cnt;
        w_load_pend_nxt = r_load_pend;
        w_seed_wr       = 1'b0;
        w_seed_clr      = 1'b0;
        w_lane_zero     = 1'b0;
        w_lane_load     = 1'b0;
        w_lane_step     = 1'b0;
        if (reseed_req) begin
            w_state_nxt     = ST_UNSEEDED;
            w_word_cnt_nxt  = 2'd0;
            w_warm_cnt_nxt  = 8'd0;
            w_load_pend_nxt = 1'b0;
            w_seed_clr      = 1'b1;
            w_lane_zero     = 1'b1;
        end else begin
            case (r_state)
                ST_UNSEEDED: begin
                    if (seed_valid) begin
                        w_seed_wr      = 1'b1;
                        w_word_cnt_nxt = 2'd1;
                        w_state_nxt    = ST_SEEDING;
                    end
                end
                ST_SEEDING: begin
                    if (seed_valid) begin
                        w_seed_wr = 1'b1;
                        if (r_word_cnt == 2'd3) begin
                            w_word_cnt_nxt  = 2'd0;
                            w_load_pend_nxt = 1'b1;
                            w_state_nxt     = ST_WARMUP;
                        end else begin
                            w_word_cnt_nxt = r_word_cnt + 2'd1;
                        end
                    end
                end
                ST_WARMUP: begin
                    // First WARMUP cycle loads the lanes, the following ones step them.
                    if (r_load_pend) begin
                        w_lane_load     = 1'b1;
                        w_load_pend_nxt = 1'b0;
                    end else begin
                        w_lane_step = 1'b1;
                        if (r_warm_cnt == C_WARM_LAST) begin
                            w_warm_cnt_nxt = 8'd0;
                            w_seed_clr     = 1'b1;
                            w_state_nxt    = ST_READY;
                        end else begin
                            w_warm_cnt_nxt = r_warm_cnt + 8'd1;
                        end
                    end
                end
                ST_READY: begin
                    w_lane_step = rnd_consume;
                end
                default: begin
                    w_state_nxt = ST_UNSEEDED;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_UNSEEDED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_cnt  <= 2'd0;
            r_warm_cnt  <= 8'd0;
            r_load_pend <= 1'b0;
            r_seed      <= 128'd0;
            r_starved   <= 1'b0;
        end else begin
            r_word_cnt  <= w_word_cnt_nxt;
            r_warm_cnt  <= w_warm_cnt_nxt;
            r_load_pend <= w_load_pend_nxt;
            if (w_seed_clr) begin
                r_seed <= 128'd0;
            end else if (w_seed_wr) begin
                r_seed[{r_word_cnt, 5'd0} +: 32] <= seed_in;
            end
            if (w_starve_set) begin
                r_starved <= 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < C_LANES; gi++) begin : g_lane
            logic [63:0] r_lane;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_lane <= 64'd0;
                end else if (w_lane_zero) begin
                    r_lane <= 64'd0;
                end else if (w_lane_load) begin
                    r_lane <= lane_init(r_seed, gi);
                end else if (w_lane_step) begin
                    r_lane <= xs_step(r_lane);
                end
            end

            assign rnd_out[64*gi +: 64] = rnd_valid ? r_lane : 64'd0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_msk_rnd_feeder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msk_rnd_feeder
//  Description : Directed self-checking bench for msk_rnd_feeder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msk_rnd_feeder;

    localparam int          RND_WIDTH = 512;
    localparam int          WARMUP    = 16;
    localparam int          LANES     = RND_WIDTH / 64;
    localparam logic [63:0] GOLDEN    = 64'h9E3779B97F4A7C15;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          seed_in;
    logic                 seed_valid;
    logic                 seed_ready;
    logic                 reseed_req;
    logic                 rnd_consume;
    logic [RND_WIDTH-1:0] rnd_out;
    logic                 rnd_valid;
    logic                 starved;

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] exp_lane [LANES];

    always #5 clk = ~clk;

    msk_rnd_feeder #(
        .RND_WIDTH (RND_WIDTH),
        .WARMUP    (WARMUP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .seed_in     (seed_in),
        .seed_valid  (seed_valid),
        .seed_ready  (seed_ready),
        .reseed_req  (reseed_req),
        .rnd_consume (rnd_consume),
        .rnd_out     (rnd_out),
        .rnd_valid   (rnd_valid),
        .starved     (starved)
    );

    function automatic logic [63:0] m_step(input logic [63:0] x);
        logic [63:0] v;
        v = x ^ (x << 13);
        v = v ^ (v >> 7);
        v = v ^ (v << 17);
        return v;
    endfunction

    function automatic logic [63:0] m_rotl(input logic [63:0] x, input int r);
        if (r == 0) return x;
        return (x << r) | (x >> (64 - r));
    endfunction

    function automatic logic [63:0] m_init(input logic [127:0] s, input int i);
        logic [63:0] v;
        v = s[63:0] ^ m_rotl(s[127:64], i % 64) ^ (GOLDEN * 64'(i + 1));
        if (v == 64'd0) v = 64'd1;
        return v;
    endfunction

    function automatic logic [RND_WIDTH-1:0] exp_vec();
        logic [RND_WIDTH-1:0] v;
        for (int i = 0; i < LANES; i++) v[64*i +: 64] = exp_lane[i];
        return v;
    endfunction

    task automatic model_step();
        for (int i = 0; i < LANES; i++) exp_lane[i] = m_step(exp_lane[i]);
    endtask

    task automatic model_seed(input logic [127:0] s);
        for (int i = 0; i < LANES; i++) exp_lane[i] = m_init(s, i);
        repeat (WARMUP) model_step();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        seed_in     = 32'd0;
        seed_valid  = 1'b0;
        reseed_req  = 1'b0;
        rnd_consume = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_words(input logic [127:0] s, input int first, input int last);
        for (int k = first; k <= last; k++) begin
            seed_in    = s[32*k +: 32];
            seed_valid = 1'b1;
            tick();
        end
        seed_valid = 1'b0;
    endtask

    // Called right after the edge that accepted the 4th word.
    task automatic check_ready(input string name, input logic [127:0] s);
        int cnt;
        cnt = 0;
        while (rnd_valid !== 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        vectors++;
        if (cnt != WARMUP + 1) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d edges, expected %0d", name, cnt, WARMUP + 1);
        end
        model_seed(s);
        vectors++;
        if (rnd_out !== exp_vec()) begin
            miscompares++;
            $display("FAIL %s_lanes: got %h expected %h", name, rnd_out, exp_vec());
        end
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (seed_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_seed_ready: got %b expected 1", seed_ready);
        end
        vectors++;
        if (rnd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rnd_valid: got %b expected 0", rnd_valid);
        end
        vectors++;
        if (rnd_out !== '0) begin
            miscompares++;
            $display("FAIL reset_rnd_out: got %h expected 0", rnd_out);
        end
        vectors++;
        if (starved !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_starved: got %b expected 0", starved);
        end
    endtask

    task automatic test_seed_latency();
        send_words(128'h1, 0, 3);
        vectors++;
        if (seed_ready !== 1'b0 || rnd_out !== '0) begin
            miscompares++;
            $display("FAIL warmup_outputs: seed_ready %b rnd_out %h expected 0 and 0", seed_ready, rnd_out);
        end
        check_ready("seed1", 128'h1);
        vectors++;
        if (rnd_out[63:0] !== 64'h0) begin
            // lane0 must have moved away from its raw seed image
            if (rnd_out[63:0] === 64'h9E3779B97F4A7C14) begin
                miscompares++;
                $display("FAIL seed1_lane0_stepped: got %h, unstepped value", rnd_out[63:0]);
            end
        end else begin
            miscompares++;
            $display("FAIL seed1_lane0_nonzero: got %h", rnd_out[63:0]);
        end
    endtask

    task automatic test_consume();
        logic [RND_WIDTH-1:0] prev;
        prev        = rnd_out;
        rnd_consume = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            model_step();
            vectors++;
            if (rnd_out !== exp_vec()) begin
                miscompares++;
                $display("FAIL consume_step%0d: got %h expected %h", c, rnd_out, exp_vec());
            end
            vectors++;
            if (rnd_out === prev) begin
                miscompares++;
                $display("FAIL consume_distinct%0d: got %h, expected a change", c, rnd_out);
            end
            prev = rnd_out;
        end
        rnd_consume = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            vectors++;
            if (rnd_out !== exp_vec()) begin
                miscompares++;
                $display("FAIL hold%0d: got %h expected %h", c, rnd_out, exp_vec());
            end
        end
    endtask

    task automatic test_zero_lane();
        logic [127:0] s;
        logic         saw_zero;
        logic         saw_diff;
        s = {64'h0, GOLDEN};
        do_reset();
        send_words(s, 0, 3);
        check_ready("zero_lane", s);
        vectors++;
        if (exp_lane[0] !== {m_step_n(64'd1)}) begin
            miscompares++;
            $display("FAIL zero_lane_model: got %h expected lane0 from init 1", exp_lane[0]);
        end
        saw_zero    = 1'b0;
        saw_diff    = 1'b0;
        rnd_consume = 1'b1;
        for (int c = 0; c < 1000; c++) begin
            tick();
            model_step();
            for (int i = 0; i < LANES; i++) begin
                if (rnd_out[64*i +: 64] === 64'd0) saw_zero = 1'b1;
            end
            if (rnd_out !== exp_vec()) saw_diff = 1'b1;
        end
        rnd_consume = 1'b0;
        vectors++;
        if (saw_zero) begin
            miscompares++;
            $display("FAIL zero_lane_1000_nonzero: got a zero lane, expected none");
        end
        vectors++;
        if (saw_diff) begin
            miscompares++;
            $display("FAIL zero_lane_1000_model: got %h expected %h", rnd_out, exp_vec());
        end
    endtask

    function automatic logic [63:0] m_step_n(input logic [63:0] x);
        logic [63:0] v;
        v = x;
        for (int k = 0; k < WARMUP; k++) v = m_step(v);
        return v;
    endfunction

    task automatic test_starved();
        do_reset();
        rnd_consume = 1'b1;
        tick();
        rnd_consume = 1'b0;
        vectors++;
        if (starved !== 1'b1 || rnd_out !== '0) begin
            miscompares++;
            $display("FAIL starve_set: starved %b rnd_out %h expected 1 and 0", starved, rnd_out);
        end
        send_words(128'h1, 0, 3);
        check_ready("starve_seed", 128'h1);
        vectors++;
        if (starved !== 1'b1) begin
            miscompares++;
            $display("FAIL starve_sticky: got %b expected 1", starved);
        end
        do_reset();
        vectors++;
        if (starved !== 1'b0) begin
            miscompares++;
            $display("FAIL starve_rst_clear: got %b expected 0", starved);
        end
    endtask

    task automatic test_reseed();
        logic [127:0] sb;
        sb = 128'h0BADF00D_11223344_55667788_99AABBCC;
        do_reset();
        send_words(128'h1, 0, 3);
        check_ready("pre_reseed", 128'h1);
        rnd_consume = 1'b1;
        reseed_req  = 1'b1;
        tick();
        rnd_consume = 1'b0;
        reseed_req  = 1'b0;
        vectors++;
        if (rnd_valid !== 1'b0 || rnd_out !== '0) begin
            miscompares++;
            $display("FAIL reseed_outputs: rnd_valid %b rnd_out %h expected 0 and 0", rnd_valid, rnd_out);
        end
        vectors++;
        if (seed_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reseed_seed_ready: got %b expected 1", seed_ready);
        end
        vectors++;
        if (starved !== 1'b0) begin
            miscompares++;
            $display("FAIL reseed_starved: got %b expected 0", starved);
        end
        // Reseed in mid-seeding with a same-cycle word: that word must be dropped.
        send_words(sb, 0, 1);
        seed_in     = sb[95:64];
        seed_valid  = 1'b1;
        reseed_req  = 1'b1;
        tick();
        seed_valid  = 1'b0;
        reseed_req  = 1'b0;
        send_words(128'h1, 0, 3);
        check_ready("reseed_repeat", 128'h1);
    endtask

    task automatic test_reset_mid();
        logic [127:0] sc;
        logic [127:0] sd;
        sc = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        sd = 128'h13579BDF_2468ACE0_FEDCBA98_76543210;
        do_reset();
        send_words(sc, 0, 1);
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (seed_ready !== 1'b1 || rnd_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL async_rst: seed_ready %b rnd_valid %b expected 1 and 0", seed_ready, rnd_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        send_words(sd, 0, 2);
        repeat (WARMUP + 4) tick();
        vectors++;
        if (rnd_valid !== 1'b0 || seed_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL partial_lost: rnd_valid %b seed_ready %b expected 0 and 1", rnd_valid, seed_ready);
        end
        send_words(sd, 3, 3);
        check_ready("after_rst", sd);
    endtask

    initial begin
        test_reset();
        test_seed_latency();
        test_consume();
        test_zero_lane();
        test_starved();
        test_reseed();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
